ex_stage_mc: RTL and testbench



---
 rtl/ex_pkg.sv | 32 +++
 rtl/iter_mul.sv | 66 ++++++
 rtl/ex_stage_mc.sv | 182 ++++++++++++++++++
 tb/tb_ex_stage_mc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, forwarding
// selects and the multiplier sequencing states. Width-independent only.
package ex_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_MUL  = 4'd10
   } alu_op_t;

   typedef enum logic [1:0] {
      FWD_REG     = 2'b00,
      FWD_MEM     = 2'b01,
      FWD_WB      = 2'b10,
      FWD_REG_ALT = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// Retires MUL_BPC multiplier bits per cycle, N = XLEN/MUL_BPC steps.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   start          load operands, clear accumulator, begin iterating
//   abort          drop any multiply in progress (wins over start)
//   a, b           multiplicand / multiplier, sampled on start
//   done           high during the final iteration cycle
//   product        accumulator; holds the full product once iteration ends
module iter_mul #(
   parameter int XLEN    = 32,
   parameter int MUL_BPC = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int N     = XLEN / MUL_BPC;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   logic             running;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  mcand, mplier, acc, digit, partial;

   // One radix-2^MUL_BPC digit of the multiplier per step; the digit is
   // zero-extended so the multiply collapses to an AND for MUL_BPC=1.
   always_comb begin
      digit = '0;
      digit[MUL_BPC-1:0] = mplier[MUL_BPC-1:0];
      partial = acc + mcand * digit;
   end

   assign done    = running && (count == CNT_W'(N - 1));
   assign product = acc;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         running <= 1'b0;
         count   <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
      end else if (abort) begin
         running <= 1'b0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
         mcand   <= a;
         mplier  <= b;
         acc     <= '0;
      end else if (running) begin
         acc    <= partial;
         mcand  <= mcand << MUL_BPC;
         mplier <= mplier >> MUL_BPC;
         count  <= count + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with MEM/WB operand forwarding, ALU, iterative multiplier
// and the EX/MEM pipeline register (hold on stall_in, bubble on stall_out,
// kill on flush).
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   valid_ex, alu_op, alu_src      ID/EX instruction and operand B select
//   ctrl_ex, rd_ex, pc4_ex         bookkeeping carried to EX/MEM
//   r_data1, r_data2, extended     register operands and immediate
//   fwd_a, fwd_b                   forwarding selects for operands A / B
//   fwd_mem_data, fwd_wb_data      forwarding sources
//   stall_in, flush                downstream stall, kill EX contents
//   stall_out                      EX busy with a multiply; hold ID/EX
//   valid_mem .. write_data1       EX/MEM register outputs
//
// state    | meaning
// MUL_IDLE | no multiply in flight; ALU results flow through
// MUL_BUSY | iter_mul retiring bits; EX/MEM receives bubbles
// MUL_DONE | product ready; captured from latched bookkeeping when !stall_in
module ex_stage_mc
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int CTRL_W  = 5,
   parameter int RD_W    = 5,
   parameter int MUL_BPC = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_ex,
   input  logic [3:0]        alu_op,
   input  logic              alu_src,
   input  logic [CTRL_W-1:0] ctrl_ex,
   input  logic [RD_W-1:0]   rd_ex,
   input  logic [XLEN-1:0]   pc4_ex,
   input  logic [XLEN-1:0]   r_data1,
   input  logic [XLEN-1:0]   r_data2,
   input  logic [XLEN-1:0]   extended,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [XLEN-1:0]   fwd_mem_data,
   input  logic [XLEN-1:0]   fwd_wb_data,
   input  logic              stall_in,
   input  logic              flush,
   output logic              stall_out,
   output logic              valid_mem,
   output logic [CTRL_W-1:0] ctrl_mem,
   output logic [RD_W-1:0]   rd_mem,
   output logic [XLEN-1:0]   pc4_mem,
   output logic [XLEN-1:0]   alu_result,
   output logic [XLEN-1:0]   write_data1
);

   localparam int SH_W = $clog2(XLEN);

   mul_state_t        state_q, state_d;
   logic [XLEN-1:0]   op_a, op_b_reg, op_b, alu_res, mul_product;
   logic [SH_W-1:0]   shamt;
   logic              is_mul, mul_start, mul_done;
   logic [CTRL_W-1:0] lat_ctrl;
   logic [RD_W-1:0]   lat_rd;
   logic [XLEN-1:0]   lat_pc4, lat_store;

   always_comb begin
      case (fwd_sel_t'(fwd_a))
         FWD_MEM: op_a = fwd_mem_data;
         FWD_WB:  op_a = fwd_wb_data;
         default: op_a = r_data1;
      endcase
      case (fwd_sel_t'(fwd_b))
         FWD_MEM: op_b_reg = fwd_mem_data;
         FWD_WB:  op_b_reg = fwd_wb_data;
         default: op_b_reg = r_data2;
      endcase
      op_b = alu_src ? extended : op_b_reg;
   end

   assign shamt = op_b[SH_W-1:0];

   // MUL has no live-path result: a valid MUL always raises stall_out, so
   // the register never captures this value for it.
   always_comb begin
      case (alu_op_t'(alu_op))
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default:  alu_res = '0;
      endcase
   end

   assign is_mul    = valid_ex && (alu_op == ALU_MUL);
   assign stall_out = ((state_q == MUL_IDLE) && is_mul) || (state_q == MUL_BUSY);

   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (is_mul && !flush && !stall_in) begin
               state_d   = MUL_BUSY;
               mul_start = 1'b1;
            end
         end
         MUL_BUSY: if (mul_done) state_d = MUL_DONE;
         MUL_DONE: if (!stall_in) state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
      if (flush) state_d = MUL_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= MUL_IDLE;
      else          state_q <= state_d;
   end

   iter_mul #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .abort   (flush),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Bookkeeping is frozen at presentation so the DONE capture does not
   // depend on what the ID/EX slot shows later.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lat_ctrl  <= '0;
         lat_rd    <= '0;
         lat_pc4   <= '0;
         lat_store <= '0;
      end else if (mul_start) begin
         lat_ctrl  <= ctrl_ex;
         lat_rd    <= rd_ex;
         lat_pc4   <= pc4_ex;
         lat_store <= op_b_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_mem   <= 1'b0;
         ctrl_mem    <= '0;
         rd_mem      <= '0;
         pc4_mem     <= '0;
         alu_result  <= '0;
         write_data1 <= '0;
      end else if (flush) begin
         valid_mem <= 1'b0;
         ctrl_mem  <= '0;
      end else if (stall_in) begin
         valid_mem <= valid_mem;
      end else if (stall_out) begin
         valid_mem <= 1'b0;
         ctrl_mem  <= '0;
      end else if (state_q == MUL_DONE) begin
         valid_mem   <= 1'b1;
         ctrl_mem    <= lat_ctrl;
         rd_mem      <= lat_rd;
         pc4_mem     <= lat_pc4;
         alu_result  <= mul_product;
         write_data1 <= lat_store;
      end else begin
         valid_mem   <= valid_ex;
         ctrl_mem    <= valid_ex ? ctrl_ex : '0;
         rd_mem      <= rd_ex;
         pc4_mem     <= pc4_ex;
         alu_result  <= alu_res;
         write_data1 <= op_b_reg;
      end
   end

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
   import ex_pkg::*;

   localparam int XLEN    = 32;
   localparam int CTRL_W  = 5;
   localparam int RD_W    = 5;
   localparam int MUL_BPC = 1;
   localparam int N       = XLEN / MUL_BPC;

   logic              clk = 1'b0;
   logic              reset_n, valid_ex, alu_src, stall_in, flush;
   logic [3:0]        alu_op;
   logic [CTRL_W-1:0] ctrl_ex, ctrl_mem;
   logic [RD_W-1:0]   rd_ex, rd_mem;
   logic [XLEN-1:0]   pc4_ex, r_data1, r_data2, extended, fwd_mem_data, fwd_wb_data;
   logic [1:0]        fwd_a, fwd_b;
   logic              stall_out, valid_mem;
   logic [XLEN-1:0]   pc4_mem, alu_result, write_data1;

   int total = 0;
   int bad   = 0;

   ex_stage_mc #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RD_W(RD_W), .MUL_BPC(MUL_BPC)) dut (
      .clk(clk), .reset_n(reset_n), .valid_ex(valid_ex), .alu_op(alu_op),
      .alu_src(alu_src), .ctrl_ex(ctrl_ex), .rd_ex(rd_ex), .pc4_ex(pc4_ex),
      .r_data1(r_data1), .r_data2(r_data2), .extended(extended),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_data(fwd_wb_data), .stall_in(stall_in), .flush(flush),
      .stall_out(stall_out), .valid_mem(valid_mem), .ctrl_mem(ctrl_mem),
      .rd_mem(rd_mem), .pc4_mem(pc4_mem), .alu_result(alu_result),
      .write_data1(write_data1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] r1, r2, ext, mem, wb;
      logic [1:0]  fa, fb;
      logic        src;
      logic [31:0] exp_res, exp_wd;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                        input logic [31:0] mem_v, input logic [31:0] wb_v);
      if (sel == 2'b01) return mem_v;
      if (sel == 2'b10) return wb_v;
      return reg_v;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return 32'($signed(a) >>> sh);
         4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      valid_ex = 1'b1; alu_op = op; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
      r_data1 = a; r_data2 = b;
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
      int          stall_cnt;
      int          edges;
      logic        seen;
      logic [31:0] prod;
      stall_cnt = 0; edges = 0; seen = 1'b0;
      prod = a * b;
      valid_ex = 1'b1; alu_op = 4'd10; alu_src = 1'b0; fwd_a = 2'b01; fwd_b = 2'b00;
      fwd_mem_data = a; r_data1 = $urandom; r_data2 = b;
      ctrl_ex = 5'h15; rd_ex = 5'd7; pc4_ex = 32'h1000;
      for (int i = 0; i < 3 * N && !seen; i++) begin
         @(negedge clk);
         if (stall_out) stall_cnt++;
         step();
         edges++;
         if (edges == 1) begin
            fwd_mem_data = ~a; r_data2 = b + 1; rd_ex = 5'd3;
            pc4_ex = 32'h2000; ctrl_ex = 5'h0A;
         end
         if (valid_mem) seen = 1'b1;
      end
      valid_ex = 1'b0;
      chk("mul_seen", 32'(seen), 32'd1);
      chk("mul_stall_cycles", 32'(stall_cnt), 32'(N + 1));
      chk("mul_latency_edges", 32'(edges), 32'(N + 2));
      chk("mul_result", alu_result, prod);
      chk("mul_rd", 32'(rd_mem), 32'd7);
      chk("mul_pc4", pc4_mem, 32'h1000);
      chk("mul_ctrl", 32'(ctrl_mem), 32'h15);
      chk("mul_store", write_data1, b);
   endtask

   initial begin
      logic              m_valid;
      logic [CTRL_W-1:0] m_ctrl;
      logic [RD_W-1:0]   m_rd;
      logic [31:0]       m_pc4, m_res, m_wd, ea, eb_reg, eb;
      logic [3:0]        rop;
      int                found;

      vecs[0]  = '{4'd0,  32'd5, 32'd0, 32'hFFFF_FFFD, 32'd100, 32'd0, 2'b01, 2'b00, 1'b1, 32'd97, 32'd0};
      vecs[1]  = '{4'd0,  32'd5, 32'd0, 32'd0, 32'd100, 32'h55, 2'b01, 2'b10, 1'b0, 32'd185, 32'h55};
      vecs[2]  = '{4'd7,  32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 32'hF800_0000, 32'd0};
      vecs[3]  = '{4'd6,  32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 32'h0800_0000, 32'd0};
      vecs[4]  = '{4'd8,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd1, 32'd1};
      vecs[5]  = '{4'd9,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0, 32'd1};
      vecs[6]  = '{4'd4,  32'h3333_3333, 32'h5555_5555, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'h6666_6666, 32'h5555_5555};
      vecs[7]  = '{4'd1,  32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1};
      vecs[8]  = '{4'd5,  32'd1, 32'd0, 32'h3F, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 32'h8000_0000, 32'd0};
      vecs[9]  = '{4'd12, 32'd1234, 32'd5678, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0, 32'd5678};
      vecs[10] = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'hF000_F000, 32'hFF00_FF00};
      vecs[11] = '{4'd3,  32'hF0, 32'h0F, 32'd0, 32'hDEAD, 32'd0, 2'b11, 2'b00, 1'b0, 32'hFF, 32'h0F};
      vecs[12] = '{4'd0,  32'hFFFF_FFFF, 32'd7, 32'd0, 32'd1, 32'd0, 2'b00, 2'b01, 1'b0, 32'd0, 32'd1};
      vecs[13] = '{4'd7,  32'd0, 32'd0, 32'd31, 32'd0, 32'hF000_0000, 2'b10, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'd0};

      reset_n = 1'b0; valid_ex = 1'b0; alu_op = 4'd0; alu_src = 1'b0;
      ctrl_ex = '0; rd_ex = '0; pc4_ex = '0; r_data1 = '0; r_data2 = '0;
      extended = '0; fwd_a = 2'b00; fwd_b = 2'b00; fwd_mem_data = '0;
      fwd_wb_data = '0; stall_in = 1'b0; flush = 1'b0;

      repeat (3) step();
      chk("rst_valid", 32'(valid_mem), 32'd0);
      chk("rst_result", alu_result, 32'd0);
      reset_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(valid_mem), 32'd0);
      chk("post_rst_ctrl", 32'(ctrl_mem), 32'd0);
      chk("post_rst_rd", 32'(rd_mem), 32'd0);
      chk("post_rst_pc4", pc4_mem, 32'd0);
      chk("post_rst_result", alu_result, 32'd0);
      chk("post_rst_wd", write_data1, 32'd0);
      chk("post_rst_stall_out", 32'(stall_out), 32'd0);

      for (int i = 0; i < 14; i++) begin
         valid_ex = 1'b1; alu_op = vecs[i].op; alu_src = vecs[i].src;
         r_data1 = vecs[i].r1; r_data2 = vecs[i].r2; extended = vecs[i].ext;
         fwd_mem_data = vecs[i].mem; fwd_wb_data = vecs[i].wb;
         fwd_a = vecs[i].fa; fwd_b = vecs[i].fb;
         ctrl_ex = 5'(i + 1); rd_ex = 5'(i + 2); pc4_ex = 32'(4 * i + 4);
         step();
         chk($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
         chk($sformatf("vec%0d_wd", i), write_data1, vecs[i].exp_wd);
         chk($sformatf("vec%0d_valid", i), 32'(valid_mem), 32'd1);
         chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_mem), 32'(i + 1));
         chk($sformatf("vec%0d_rd", i), 32'(rd_mem), 32'(i + 2));
         chk($sformatf("vec%0d_pc4", i), pc4_mem, 32'(4 * i + 4));
      end

      // Random non-MUL traffic with flush/stall_in against a register model.
      m_valid = valid_mem; m_ctrl = ctrl_mem; m_rd = rd_mem;
      m_pc4 = pc4_mem; m_res = alu_result; m_wd = write_data1;
      m_valid = 1'b1; m_ctrl = 5'd14; m_rd = 5'd15; m_pc4 = 32'd56;
      m_res = 32'hFFFF_FFFF; m_wd = 32'd0;
      for (int i = 0; i < 300; i++) begin
         do rop = 4'($urandom_range(0, 15)); while (rop == 4'd10);
         valid_ex = ($urandom_range(0, 3) != 0); alu_op = rop;
         alu_src = $urandom_range(0, 1) == 1;
         r_data1 = $urandom; r_data2 = $urandom; extended = $urandom;
         fwd_mem_data = $urandom; fwd_wb_data = $urandom;
         fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
         ctrl_ex = 5'($urandom); rd_ex = 5'($urandom); pc4_ex = $urandom;
         flush = ($urandom_range(0, 15) == 0);
         stall_in = ($urandom_range(0, 7) == 0);
         ea = pick(fwd_a, r_data1, fwd_mem_data, fwd_wb_data);
         eb_reg = pick(fwd_b, r_data2, fwd_mem_data, fwd_wb_data);
         eb = alu_src ? extended : eb_reg;
         if (flush) begin
            m_valid = 1'b0; m_ctrl = '0;
         end else if (!stall_in) begin
            m_valid = valid_ex; m_ctrl = valid_ex ? ctrl_ex : '0;
            m_rd = rd_ex; m_pc4 = pc4_ex; m_res = ref_alu(rop, ea, eb); m_wd = eb_reg;
         end
         #2;
         chk("rnd_stall_out", 32'(stall_out), 32'd0);
         step();
         chk("rnd_valid", 32'(valid_mem), 32'(m_valid));
         chk("rnd_ctrl", 32'(ctrl_mem), 32'(m_ctrl));
         if (m_valid) begin
            chk("rnd_result", alu_result, m_res);
            chk("rnd_wd", write_data1, m_wd);
            chk("rnd_rd", 32'(rd_mem), 32'(m_rd));
            chk("rnd_pc4", pc4_mem, m_pc4);
         end
      end
      flush = 1'b0; stall_in = 1'b0; valid_ex = 1'b0;
      step();

      run_mul(32'hFFFF_FFF9, 32'd6);
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_mul(32'd0, 32'h1234_5678);
      for (int i = 0; i < 3; i++) run_mul($urandom, $urandom);

      // Flush in the 10th BUSY cycle: multiply aborted, no product.
      set_op(4'd10, 32'd9, 32'd9);
      step();
      repeat (9) step();
      flush = 1'b1; valid_ex = 1'b0;
      step();
      flush = 1'b0;
      alu_op = 4'd0; r_data1 = '0; r_data2 = '0;
      chk("flush_stall_out", 32'(stall_out), 32'd0);
      chk("flush_valid", 32'(valid_mem), 32'd0);
      for (int i = 0; i < N + 8; i++) begin
         step();
         chk("flush_no_product_valid", 32'(valid_mem), 32'd0);
         chk("flush_no_product_stall", 32'(stall_out), 32'd0);
      end

      // Reset in the middle of BUSY clears everything.
      set_op(4'd0, 32'h11, 32'h22); ctrl_ex = 5'd3; rd_ex = 5'd9; pc4_ex = 32'h44;
      step();
      chk("pre_rst_add", alu_result, 32'h33);
      set_op(4'd10, 32'd5, 32'd5);
      step();
      repeat (5) step();
      reset_n = 1'b0; valid_ex = 1'b0;
      step();
      chk("midrst_valid", 32'(valid_mem), 32'd0);
      chk("midrst_ctrl", 32'(ctrl_mem), 32'd0);
      chk("midrst_rd", 32'(rd_mem), 32'd0);
      chk("midrst_pc4", pc4_mem, 32'd0);
      chk("midrst_result", alu_result, 32'd0);
      chk("midrst_wd", write_data1, 32'd0);
      chk("midrst_stall_out", 32'(stall_out), 32'd0);
      reset_n = 1'b1; alu_op = 4'd0; r_data1 = '0; r_data2 = '0;
      ctrl_ex = '0; rd_ex = '0; pc4_ex = '0;
      for (int i = 0; i < N + 8; i++) begin
         step();
         chk("midrst_no_product_valid", 32'(valid_mem), 32'd0);
         chk("midrst_no_product_stall", 32'(stall_out), 32'd0);
      end

      // stall_in held for 3 cycles in DONE, then one capture and an ADD.
      set_op(4'd10, 32'd123, 32'd1000); ctrl_ex = 5'd6; rd_ex = 5'd11; pc4_ex = 32'h800;
      found = 0;
      for (int i = 0; i < 3 * N && found == 0; i++) begin
         step();
         #2;
         if (!stall_out) found = i + 1;
      end
      chk("done_reached_edges", 32'(found), 32'(N + 1));
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         #2;
         chk("done_hold_valid", 32'(valid_mem), 32'd0);
         chk("done_hold_stall_out", 32'(stall_out), 32'd0);
      end
      stall_in = 1'b0;
      step();
      chk("done_capture_valid", 32'(valid_mem), 32'd1);
      chk("done_capture_result", alu_result, 32'd123000);
      chk("done_capture_rd", 32'(rd_mem), 32'd11);
      set_op(4'd0, 32'd2, 32'd3); ctrl_ex = 5'd1; rd_ex = 5'd4;
      step();
      chk("after_mul_add_valid", 32'(valid_mem), 32'd1);
      chk("after_mul_add_result", alu_result, 32'd5);
      chk("after_mul_add_rd", 32'(rd_mem), 32'd4);
      valid_ex = 1'b0;
      step();
      chk("after_mul_bubble", 32'(valid_mem), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
